// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_rd_arbiter_pkg
// Brief   : Shared IDs, FSM encoding and AXI size codes for the read arbiter
// Revision: 1.0 - initial release
// ============================================================================
package axi_rd_arbiter_pkg;

  // AXI IDs used on AR/R to tell the two requesters apart
  localparam logic [3:0] ARID_INST = 4'd0;
  localparam logic [3:0] ARID_DATA = 4'd1;

  // AXI AxSIZE encodings
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Arbiter FSM: IDLE accepts a request, AR holds it until the handshake
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_AR   = 1'b1
  } state_e;

endpackage : axi_rd_arbiter_pkg
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_rd_arbiter
// Brief   : Shares one AXI AR/R channel between the inst-side and data-side
//           sram-like read requesters; tracks outstanding reads per ID,
//           routes R beats back by ID and blocks data reads that hit a word
//           with a write still in flight.
// Revision: 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        aclk,
  input  logic        areset,
  // inst-side requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data-side requester
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // shared read data
  output logic [31:0] resp_rdata,
  // write-path hazard information
  input  logic        wr_pending,
  input  logic [31:0] wr_addr,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] C_MAX_OUT    = CW'(MAX_OUT);
  localparam logic [SW-1:0] C_STARVE_LIM = SW'(STARVE_LIM);

  state_e        state_q,   state_d;
  logic          arvalid_q, arvalid_d;
  logic [31:0]   araddr_q,  araddr_d;
  logic [3:0]    arid_q,    arid_d;
  logic [2:0]    arsize_q,  arsize_d;
  logic          rready_q,  rready_d;
  logic [CW-1:0] cnt_i_q,   cnt_i_d;
  logic [CW-1:0] cnt_d_q,   cnt_d_d;
  logic [SW-1:0] starve_q,  starve_d;

  logic el_i;
  logic el_d;
  logic raw;
  logic gnt_i;
  logic gnt_d;
  logic r_fire;
  logic dec_i;
  logic dec_d;

  // Byte lane bits of the write address do not take part in the word compare
  logic unused_wr_lsb;
  assign unused_wr_lsb = ^wr_addr[1:0];

  // Eligibility: room for another outstanding read, and no RAW hazard on data
  always_comb begin
    raw  = wr_pending && (wr_addr[31:2] == data_addr[31:2]);
    el_i = inst_req && (cnt_i_q < C_MAX_OUT);
    el_d = data_req && (cnt_d_q < C_MAX_OUT) && !raw;
  end

  // Next-state, grant and AR field capture; data wins unless inst is starving
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arsize_d  = arsize_q;
    starve_d  = starve_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_i = el_i && (!el_d || (starve_q == C_STARVE_LIM));
        gnt_d = el_d && !gnt_i;
        if (gnt_i) begin
          state_d   = ST_AR;
          arvalid_d = 1'b1;
          araddr_d  = inst_addr;
          arid_d    = ARID_INST;
          arsize_d  = SIZE_WORD;
          starve_d  = '0;
        end else if (gnt_d) begin
          state_d   = ST_AR;
          arvalid_d = 1'b1;
          araddr_d  = data_addr;
          arid_d    = ARID_DATA;
          arsize_d  = {1'b0, data_size};
          if (el_i && (starve_q != C_STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      ST_AR: begin
        if (arvalid_q && arready) begin
          state_d   = ST_IDLE;
          arvalid_d = 1'b0;
        end
      end
    endcase
  end

  // R beat routing; a beat for an ID with no reads in flight leaves its count at 0
  always_comb begin
    rready_d = 1'b1;
    r_fire   = rvalid && rready_q;
    dec_i    = r_fire && (rid == ARID_INST) && (cnt_i_q != '0);
    dec_d    = r_fire && (rid == ARID_DATA) && (cnt_d_q != '0);
  end

  // Outstanding counters: grant adds one, returning beat removes one
  always_comb begin
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    if (gnt_i && !dec_i) begin
      cnt_i_d = cnt_i_q + CW'(1);
    end else if (!gnt_i && dec_i) begin
      cnt_i_d = cnt_i_q - CW'(1);
    end
    if (gnt_d && !dec_d) begin
      cnt_d_d = cnt_d_q + CW'(1);
    end else if (!gnt_d && dec_d) begin
      cnt_d_d = cnt_d_q - CW'(1);
    end
  end

  // State and AR register bank; reset drops arvalid immediately
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      arsize_q  <= '0;
      rready_q  <= 1'b0;
      cnt_i_q   <= '0;
      cnt_d_q   <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arsize_q  <= arsize_d;
      rready_q  <= rready_d;
      cnt_i_q   <= cnt_i_d;
      cnt_d_q   <= cnt_d_d;
      starve_q  <= starve_d;
    end
  end

  // Requester-facing handshakes and AXI outputs
  always_comb begin
    inst_addr_ok = gnt_i;
    data_addr_ok = gnt_d;
    inst_data_ok = r_fire && (rid == ARID_INST);
    data_data_ok = r_fire && (rid == ARID_DATA);
    resp_rdata   = rdata;
    arvalid      = arvalid_q;
    araddr       = araddr_q;
    arid         = arid_q;
    arsize       = arsize_q;
    rready       = rready_q;
  end

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_rd_arbiter
// Brief   : Directed self-checking bench for axi_rd_arbiter. Two instances
//           share all inputs: dut (MAX_OUT=2) and dut15 (MAX_OUT=15) for the
//           starvation scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        wr_pending;
  logic [31:0] wr_addr;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] resp_rdata, araddr;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic        arvalid, rready;

  logic        inst_addr_ok_b, inst_data_ok_b, data_addr_ok_b, data_data_ok_b;
  logic [31:0] resp_rdata_b, araddr_b;
  logic [3:0]  arid_b;
  logic [2:0]  arsize_b;
  logic        arvalid_b, rready_b;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.MAX_OUT(2), .STARVE_LIM(4)) dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .resp_rdata(resp_rdata), .wr_pending(wr_pending), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid),
    .rready(rready)
  );

  axi_rd_arbiter #(.MAX_OUT(15), .STARVE_LIM(4)) dut15 (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok_b), .inst_data_ok(inst_data_ok_b),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok_b), .data_data_ok(data_data_ok_b),
    .resp_rdata(resp_rdata_b), .wr_pending(wr_pending), .wr_addr(wr_addr),
    .arid(arid_b), .araddr(araddr_b), .arsize(arsize_b), .arvalid(arvalid_b),
    .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid),
    .rready(rready_b)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Hold reset for two edges with idle inputs, release just after an edge
  task automatic do_reset();
    areset     = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_addr  = 32'h0;
    data_size  = 2'd0;
    wr_pending = 1'b0;
    wr_addr    = 32'h0;
    arready    = 1'b0;
    rid        = 4'd0;
    rdata      = 32'h0;
    rvalid     = 1'b0;
    step();
    step();
    areset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #3;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", araddr); end
    checks++; if ({arid, arsize} !== 7'h0) begin errors++; $display("FAIL reset_arid_arsize: got %h/%h expected 0/0", arid, arsize); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", rready); end
    do_reset();
    @(negedge aclk);
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL reset_rready_after: got %b expected 1", rready); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL reset_addr_ok_idle: got %b expected 00", {inst_addr_ok, data_addr_ok}); end
  endtask

  task automatic test_inst_read();
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h1c000000;
    arready   = 1'b1;
    @(negedge aclk);
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL t1_inst_addr_ok: got %b expected 1", inst_addr_ok); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL t1_arvalid_c0: got %b expected 0", arvalid); end
    step();
    inst_req = 1'b0;
    @(negedge aclk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL t1_arvalid_c1: got %b expected 1", arvalid); end
    checks++; if (araddr !== 32'h1c000000) begin errors++; $display("FAIL t1_araddr: got %h expected 1c000000", araddr); end
    checks++; if (arid !== 4'd0) begin errors++; $display("FAIL t1_arid: got %0d expected 0", arid); end
    checks++; if (arsize !== 3'd2) begin errors++; $display("FAIL t1_arsize: got %0d expected 2", arsize); end
    step();
    rvalid = 1'b1;
    rid    = 4'd0;
    rdata  = 32'h02800000;
    @(negedge aclk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL t1_arvalid_after_hs: got %b expected 0", arvalid); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL t1_data_ok: got %b expected 10", {inst_data_ok, data_data_ok}); end
    checks++; if (resp_rdata !== 32'h02800000) begin errors++; $display("FAIL t1_resp_rdata: got %h expected 02800000", resp_rdata); end
    step();
    rvalid = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h00001000;
    data_req  = 1'b1;
    data_addr = 32'h00002004;
    data_size = 2'd2;
    arready   = 1'b1;
    @(negedge aclk);
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL t2_first_grant: got %b expected 01", {inst_addr_ok, data_addr_ok}); end
    step();
    data_req = 1'b0;
    @(negedge aclk);
    checks++; if ({arvalid, arid} !== 5'h11) begin errors++; $display("FAIL t2_ar_data: got arvalid=%b arid=%0d expected 1/1", arvalid, arid); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL t2_no_accept_in_ar: got %b expected 00", {inst_addr_ok, data_addr_ok}); end
    step();
    @(negedge aclk);
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL t2_inst_second: got %b expected 1", inst_addr_ok); end
    step();
    inst_req = 1'b0;
    @(negedge aclk);
    checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h00001000}) begin errors++; $display("FAIL t2_ar_inst: got %b/%0d/%h expected 1/0/00001000", arvalid, arid, araddr); end
    step();
  endtask

  task automatic test_starvation();
    logic exp_d;
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h00000100;
    data_req  = 1'b1;
    data_addr = 32'h00000200;
    data_size = 2'd2;
    arready   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_d = (k < 4);
      @(negedge aclk);
      checks++; if ({inst_addr_ok_b, data_addr_ok_b} !== {~exp_d, exp_d}) begin errors++; $display("FAIL t3_grant_%0d: got %b expected %b", k, {inst_addr_ok_b, data_addr_ok_b}, {~exp_d, exp_d}); end
      step();
      @(negedge aclk);
      checks++; if (arid_b !== {3'd0, exp_d}) begin errors++; $display("FAIL t3_arid_%0d: got %0d expected %0d", k, arid_b, exp_d); end
      step();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic test_raw();
    do_reset();
    wr_pending = 1'b1;
    wr_addr    = 32'h00000008;
    data_req   = 1'b1;
    data_addr  = 32'h0000000A;
    data_size  = 2'd1;
    inst_req   = 1'b1;
    inst_addr  = 32'h00000300;
    arready    = 1'b1;
    @(negedge aclk);
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL t4_inst_served: got %b expected 10", {inst_addr_ok, data_addr_ok}); end
    step();
    inst_req = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL t4_blocked_%0d: got %b expected 0", k, data_addr_ok); end
      step();
    end
    wr_pending = 1'b0;
    @(negedge aclk);
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t4_released: got %b expected 1", data_addr_ok); end
    step();
    data_req = 1'b0;
    @(negedge aclk);
    checks++; if ({arid, araddr, arsize} !== {4'd1, 32'h0000000A, 3'd1}) begin errors++; $display("FAIL t4_ar_fields: got %0d/%h/%0d expected 1/0000000a/1", arid, araddr, arsize); end
    step();
  endtask

  task automatic test_max_out();
    do_reset();
    data_req  = 1'b1;
    data_addr = 32'h00000040;
    data_size = 2'd2;
    arready   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t5_accept_%0d: got %b expected 1", k, data_addr_ok); end
      step();
      step();
    end
    @(negedge aclk);
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL t5_third_blocked: got %b expected 0", data_addr_ok); end
    step();
    rvalid = 1'b1;
    rid    = 4'd1;
    rdata  = 32'hCAFEF00D;
    @(negedge aclk);
    checks++; if ({data_addr_ok, data_data_ok, inst_data_ok} !== 3'b010) begin errors++; $display("FAIL t5_rbeat_cycle: got %b expected 010", {data_addr_ok, data_data_ok, inst_data_ok}); end
    step();
    rvalid = 1'b0;
    @(negedge aclk);
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t5_third_granted: got %b expected 1", data_addr_ok); end
    step();
    data_req = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    data_req  = 1'b1;
    data_addr = 32'h00000080;
    data_size = 2'd2;
    arready   = 1'b0;
    @(negedge aclk);
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t6_first_accept: got %b expected 1", data_addr_ok); end
    step();
    data_req = 1'b0;
    @(negedge aclk);
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL t6_arvalid_before: got %b expected 1", arvalid); end
    #2;
    areset = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL t6_arvalid_async_drop: got %b expected 0", arvalid); end
    step();
    @(negedge aclk);
    areset    = 1'b0;
    data_req  = 1'b1;
    arready   = 1'b1;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t6_fresh_accept: got %b expected 1", data_addr_ok); end
    step();
    step();
    @(negedge aclk);
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL t6_cnt_cleared: got %b expected 1", data_addr_ok); end
    step();
    data_req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_inst_read();
    test_priority();
    test_starvation();
    test_raw();
    test_max_out();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_axi_rd_arbiter
`default_nettype wire
